// File: rtl/key_press_decoder_pkg.sv
// Shared definitions for the key gesture decoder: FSM state encoding,
// default timing constants and the counter-width helper.
// Imported by the decoder and by any future key-handling blocks.
package key_press_decoder_pkg;

  // 3-bit binary state encoding, kept stable for blocks that share it.
  typedef enum logic [2:0] {
    ST_DISARM = 3'd0,  // waiting for a release after reset
    ST_IDLE   = 3'd1,  // key released, no gesture in progress
    ST_PRESS1 = 3'd2,  // first press of a gesture, timing for long press
    ST_WAIT2  = 3'd3,  // released after first press, timing the double-click gap
    ST_PRESS2 = 3'd4,  // second press of a double click
    ST_HOLD   = 3'd5   // long press active, auto-repeat running
  } state_t;

  // Default timings for a 50 MHz system clock.
  localparam int unsigned DEF_LONG_CNT   = 50_000_000;  // 1.0 s
  localparam int unsigned DEF_DBL_GAP    = 12_500_000;  // 0.25 s
  localparam int unsigned DEF_REPEAT_CNT = 10_000_000;  // 0.2 s

  // Width of a counter able to hold the largest of the three timings.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_press_decoder_if.sv
// Key level in, gesture events out, grouped for the decoder port list.
// master: the side that supplies the key level and consumes events.
// slave:  the decoder itself.
interface key_press_decoder_if;

  logic key_in;        // debounced key level, 0 = pressed
  logic short_press;   // 1-cycle pulse
  logic long_press;    // 1-cycle pulse
  logic repeat_pulse;  // 1-cycle pulse while held
  logic double_click;  // 1-cycle pulse
  logic key_held;      // level, high while in HOLD

  modport master (
    output key_in,
    input  short_press,
    input  long_press,
    input  repeat_pulse,
    input  double_click,
    input  key_held
  );

  modport slave (
    input  key_in,
    output short_press,
    output long_press,
    output repeat_pulse,
    output double_click,
    output key_held
  );

endinterface

// File: rtl/key_press_decoder.sv
// Classifies a debounced active-low key into short/long/repeat/double-click events.
// Latency: every output is registered; an event appears the cycle after the deciding edge.
// No backpressure: events are fire-and-forget single-cycle pulses.
module key_press_decoder
  import key_press_decoder_pkg::*;
#(
  // All three timings must be >= 2; the counters rely on a start value of 1.
  parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
  parameter int unsigned DBL_GAP    = DEF_DBL_GAP,
  parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic                clk,
  input  logic                rst,
  key_press_decoder_if.slave  kp
);

  localparam int unsigned CNT_W = cnt_width(LONG_CNT, DBL_GAP, REPEAT_CNT);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // PRESS1 and HOLD decide on the incremented count, so they compare one early.
  localparam logic [CNT_W-1:0] LONG_HIT = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_HIT  = CNT_W'(REPEAT_CNT - 1);
  // WAIT2 decides on the current count: the gap expires DBL_GAP edges after release.
  localparam logic [CNT_W-1:0] GAP_HIT  = CNT_W'(DBL_GAP);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pressed;

  logic short_q;
  logic long_q;
  logic repeat_q;
  logic double_q;
  logic held_q;

  assign pressed = (kp.key_in == 1'b0);

  // Shared counter increment, saturating at all-ones instead of wrapping.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CNT_MAX) begin
      cnt_inc = cnt + CNT_ONE;
    end
  end

  // Gesture FSM with the shared counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_DISARM;
      cnt      <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      double_q <= 1'b0;

      case (state)
        // A key already held when reset releases must be let go first.
        ST_DISARM: begin
          cnt <= '0;
          if (!pressed) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (pressed) begin
            state <= ST_PRESS1;
            cnt   <= CNT_ONE;
          end
        end

        ST_PRESS1: begin
          if (!pressed) begin
            state <= ST_WAIT2;
            cnt   <= CNT_ONE;
          end else if (cnt == LONG_HIT) begin
            long_q <= 1'b1;
            held_q <= 1'b1;
            state  <= ST_HOLD;
            cnt    <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Gap expiry wins over a new press on the same edge; that press then
        // starts a fresh gesture rather than being dropped.
        ST_WAIT2: begin
          if (cnt == GAP_HIT) begin
            short_q <= 1'b1;
            if (pressed) begin
              state <= ST_PRESS1;
              cnt   <= CNT_ONE;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end else if (pressed) begin
            state <= ST_PRESS2;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Second press never turns into a long press, however long it lasts.
        ST_PRESS2: begin
          if (!pressed) begin
            double_q <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        // Releasing out of HOLD ends the gesture silently.
        ST_HOLD: begin
          if (!pressed) begin
            held_q <= 1'b0;
            state  <= ST_IDLE;
            cnt    <= '0;
          end else if (cnt == REP_HIT) begin
            repeat_q <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        // Unused encodings recover through DISARM so a stuck key is not misread.
        default: begin
          state  <= ST_DISARM;
          cnt    <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign kp.short_press  = short_q;
  assign kp.long_press   = long_q;
  assign kp.repeat_pulse = repeat_q;
  assign kp.double_click = double_q;
  assign kp.key_held     = held_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder with short timings (LONG 8, GAP 6, REPEAT 4).
// Each step drives key_in for one edge, then compares all five outputs.
module tb_key_press_decoder;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] SHORT = 5'b10000;
  localparam logic [4:0] LONG  = 5'b01000;
  localparam logic [4:0] REP   = 5'b00100;
  localparam logic [4:0] DBL   = 5'b00010;
  localparam logic [4:0] HELD  = 5'b00001;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  key_press_decoder_if kp_if ();

  key_press_decoder #(
    .LONG_CNT   (8),
    .DBL_GAP    (6),
    .REPEAT_CNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if.slave)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Drive key for the next rising edge, then sample one half-period later.
  task automatic step(input logic k, input logic [4:0] exp, input string tag);
    logic [4:0] obs;
    kp_if.key_in = k;
    @(posedge clk);
    #1;
    obs = {kp_if.short_press, kp_if.long_press, kp_if.repeat_pulse,
           kp_if.double_click, kp_if.key_held};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b (short,long,rep,dbl,held)",
                tag, obs, exp);
  endtask

  task automatic steps(input logic k, input int n, input logic [4:0] exp,
                       input string tag);
    for (int i = 0; i < n; i++) step(k, exp, tag);
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    rst          = 1'b1;
    kp_if.key_in = 1'b0;

    // 1: reset with key held, then held key stays ignored until released.
    steps(1'b0, 3, NONE, "reset");
    rst = 1'b0;
    steps(1'b0, 20, NONE, "disarm_held");
    step(1'b1, NONE, "arm");

    // 2: short press, event 6 edges after the release edge.
    steps(1'b0, 3, NONE, "short_press_low");
    step(1'b1, NONE, "short_release");
    steps(1'b1, 5, NONE, "short_gap");
    step(1'b1, SHORT, "short_event");
    step(1'b1, NONE, "short_single");

    // 3: long press on E0+7, repeats every 4 HOLD edges, silent release.
    steps(1'b0, 7, NONE, "long_wait");
    step(1'b0, LONG | HELD, "long_event");
    for (int k = 1; k <= 12; k++)
      step(1'b0, (k % 4 == 0) ? (REP | HELD) : HELD, "hold_repeat");
    step(1'b1, NONE, "hold_release");
    steps(1'b1, 8, NONE, "no_short_after_hold");

    // 4: double click, gap of 2 released edges.
    steps(1'b0, 3, NONE, "dbl_press1");
    steps(1'b1, 2, NONE, "dbl_gap");
    steps(1'b0, 3, NONE, "dbl_press2");
    step(1'b1, DBL, "dbl_event");
    steps(1'b1, 8, NONE, "dbl_no_short");

    // 4b: second press held well past LONG_CNT still yields only a double click.
    steps(1'b0, 3, NONE, "dbl_long_press1");
    steps(1'b1, 2, NONE, "dbl_long_gap");
    steps(1'b0, 12, NONE, "dbl_long_press2");
    step(1'b1, DBL, "dbl_long_event");
    steps(1'b1, 7, NONE, "dbl_long_quiet");

    // 4c: second press at the last in-gap edge (count 5) still counts.
    steps(1'b0, 3, NONE, "gap_edge_press1");
    steps(1'b1, 5, NONE, "gap_edge_gap");
    steps(1'b0, 3, NONE, "gap_edge_press2");
    step(1'b1, DBL, "gap_edge_dbl");
    steps(1'b1, 7, NONE, "gap_edge_quiet");

    // 5: press lands on the gap-expiry edge: short fires, new gesture starts.
    steps(1'b0, 3, NONE, "expiry_press1");
    steps(1'b1, 6, NONE, "expiry_gap");
    step(1'b0, SHORT, "expiry_short");
    steps(1'b0, 2, NONE, "expiry_press_new");
    step(1'b1, NONE, "expiry_release");
    steps(1'b1, 5, NONE, "expiry_gap2");
    step(1'b1, SHORT, "expiry_short2");
    step(1'b1, NONE, "expiry_single");

    // 6: reset while in HOLD, key still held -> disarmed until released.
    steps(1'b0, 7, NONE, "rst_long_wait");
    step(1'b0, LONG | HELD, "rst_long_event");
    step(1'b0, HELD, "rst_hold");
    rst = 1'b1;
    step(1'b0, NONE, "rst_in_hold");
    rst = 1'b0;
    steps(1'b0, 12, NONE, "rst_disarm_held");
    step(1'b1, NONE, "rst_rearm");
    steps(1'b0, 3, NONE, "rst_press");
    step(1'b1, NONE, "rst_release");
    steps(1'b1, 5, NONE, "rst_gap");
    step(1'b1, SHORT, "rst_short");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
